fight_round_ctrl: RTL and testbench
===================================

Name: fight_round_ctrl

Overview:
- Sequences one fight round for the display path: intro hold, fight, KO display, result wait, then re-arm.
- Owns both fighters' health registers and arbitrates their damage requests onto one shared saturating subtractor.
- Drives RyuHealth, AkumaHealth and death into the colour mapper, plus KO blink and a freeze flag for the movement logic.

Parameters:
- MAX_HEALTH, 8'd200: health loaded on reset and on re-arm.
- INTRO_FRAMES, 120: frames held in INTRO before FIGHT.
- KO_FRAMES, 180: frames held in KO before RESULT.
- BLINK_FRAMES, 15: frames per ko_blink half-period.

Ports:
- vga_clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- frame_tick  in  1  one-cycle pulse per video frame.
- start  in  1  one-cycle pulse; leaves RESULT.
- ryu_hit_req  in  1  Ryu lands a hit on Akuma; held until ack.
- ryu_hit_dmg  in  8  damage to Akuma; stable while req is high.
- ryu_hit_ack  out  1  one-cycle acknowledge.
- akuma_hit_req  in  1  Akuma lands a hit on Ryu; held until ack.
- akuma_hit_dmg  in  8  damage to Ryu.
- akuma_hit_ack  out  1  one-cycle acknowledge.
- RyuHealth  out  8  registered.
- AkumaHealth  out  8  registered.
- death  out  1  high in KO and RESULT.
- ko_blink  out  1  KO banner gate.
- freeze  out  1  high outside FIGHT.
- winner  out  2  00 none, 01 Ryu, 10 Akuma.
- state_o  out  2  current state, for debug.

Behaviour:
- Reset values: state INTRO, both healths MAX_HEALTH, frame counter 0, rr_ptr 0, all acks 0, death 0, ko_blink 0, freeze 1, winner 00.
- States and transitions:
  - INTRO: count frame_tick. On the tick that makes the count INTRO_FRAMES, go to FIGHT and clear the counter.
  - FIGHT: if either health reads 0 in the cycle after an update, go to KO and clear the counter.
  - KO: count frame_tick. At KO_FRAMES, go to RESULT.
  - RESULT: on start, reload both healths to MAX_HEALTH, clear winner, go to INTRO.
- Arbitration (FIGHT only):
  - Serve at most one request per cycle.
  - If only one request is high, serve it.
  - If both are high, serve the one not served last (rr_ptr), then toggle rr_ptr.
  - Serving a request asserts its ack for exactly one cycle. In that same cycle the target health register is written: health = (health > dmg) ? health - dmg : 0. Unsigned 8-bit, no wrap.
  - The new health is visible on the port the cycle after ack.
  - The requester drops req the cycle after ack. A req still high after ack is a new hit.
- Zero health:
  - When a write produces 0, winner is set to the attacker in the same cycle.
  - The state becomes KO at the next edge. A request arriving in that next cycle is not served in FIGHT.
- Requests outside FIGHT: acked in one cycle, damage discarded, health unchanged, same round-robin rule. Requesters never hang.
- dmg = 0: acked, health unchanged.
- ko_blink:
  - In KO, starts at 1 on KO entry and toggles every BLINK_FRAMES frame_ticks.
  - In RESULT, held at 1.
  - Otherwise 0.
- death = (state == KO or RESULT). freeze = (state != FIGHT).
- frame_tick and a hit in the same cycle are handled independently.
- start outside RESULT is ignored.
- reset_n low at any time: immediate return to reset values regardless of state or pending handshake.

Decomposition:
- Shared package fight_pkg holds:
  - round_state_t enum {INTRO, FIGHT, KO, RESULT}, 2 bits.
  - winner_t encoding.
  - HEALTH_W = 8.
- One sub-module, hit_arbiter: two req/ack pairs with round-robin pointer; outputs grant and selected damage.
- Saturating subtract and the FSM stay in fight_round_ctrl.

Test Plan:
- Reset, then 120 frame_ticks: freeze=1 and state INTRO through tick 119; FIGHT, freeze=0 after tick 120; healths 200/200.
- In FIGHT, ryu_hit_req with dmg 30: ryu_hit_ack one cycle; AkumaHealth=170 next cycle; RyuHealth=200.
- Both reqs high for the same cycle, dmg 10 each, rr_ptr=0: Ryu acked first (AkumaHealth 190), Akuma acked next cycle (RyuHealth 190). Repeat: order stays fair, no starvation.
- AkumaHealth=20, ryu dmg 50: AkumaHealth=0 (saturate), winner=01, KO next cycle, death=1, ko_blink=1, toggling every 15 ticks. After 180 ticks RESULT, ko_blink=1. start: healths 200, winner 00, INTRO.
- akuma_hit_req in INTRO and in RESULT: acked in 1 cycle, RyuHealth unchanged.
- reset_n pulsed low mid-KO, and while a req is pending: state INTRO, healths 200, no ack issued during reset.

Source files
------------

// File: rtl/fight_pkg.sv
// rtl/fight_pkg.sv - shared types and widths for the fight round controller
package fight_pkg;

    localparam int HEALTH_W = 8;

    typedef enum logic [1:0] {
        INTRO  = 2'd0,
        FIGHT  = 2'd1,
        KO     = 2'd2,
        RESULT = 2'd3
    } round_state_t;

    typedef enum logic [1:0] {
        WIN_NONE  = 2'b00,
        WIN_RYU   = 2'b01,
        WIN_AKUMA = 2'b10
    } winner_t;

endpackage

// File: rtl/hit_arbiter.sv
// rtl/hit_arbiter.sv - round-robin grant of two hit requests onto one damage path
module hit_arbiter
    import fight_pkg::*;
(
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    input  logic                req_a,
    input  logic [HEALTH_W-1:0] dmg_a,
    input  logic                req_b,
    input  logic [HEALTH_W-1:0] dmg_b,
    output logic                grant_a,
    output logic                grant_b,
    output logic [HEALTH_W-1:0] sel_dmg
);

    // 0: side a wins the next contention, 1: side b wins it
    logic rr_ptr;

    // Pointer only moves when both sides compete, so a lone request never shifts fairness
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr <= 1'b0;
        end else if (enable && req_a && req_b) begin
            rr_ptr <= ~rr_ptr;
        end
    end

    // Single-cycle grant; acks are combinational so the requester can drop req next cycle
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (enable) begin
            if (req_a && req_b) begin
                grant_a = ~rr_ptr;
                grant_b = rr_ptr;
            end else begin
                grant_a = req_a;
                grant_b = req_b;
            end
        end
        sel_dmg = grant_b ? dmg_b : dmg_a;
    end

endmodule

// File: rtl/fight_round_ctrl.sv
// rtl/fight_round_ctrl.sv - round sequencer, health registers and KO display gating
module fight_round_ctrl
    import fight_pkg::*;
#(
    parameter logic [HEALTH_W-1:0] MAX_HEALTH   = 8'd200,
    parameter int                  INTRO_FRAMES = 120,
    parameter int                  KO_FRAMES    = 180,
    parameter int                  BLINK_FRAMES = 15
) (
    input  logic                vga_clk,
    input  logic                reset_n,
    input  logic                frame_tick,
    input  logic                start,
    input  logic                ryu_hit_req,
    input  logic [HEALTH_W-1:0] ryu_hit_dmg,
    output logic                ryu_hit_ack,
    input  logic                akuma_hit_req,
    input  logic [HEALTH_W-1:0] akuma_hit_dmg,
    output logic                akuma_hit_ack,
    output logic [HEALTH_W-1:0] RyuHealth,
    output logic [HEALTH_W-1:0] AkumaHealth,
    output logic                death,
    output logic                ko_blink,
    output logic                freeze,
    output logic [1:0]          winner,
    output logic [1:0]          state_o
);

    localparam int CNT_W = 8;

    round_state_t        state, next_state;
    logic [CNT_W-1:0]    frame_cnt;
    logic [3:0]          blink_cnt;
    logic                run_q;
    winner_t             winner_q;
    logic [HEALTH_W-1:0] ryu_health, akuma_health;
    logic [HEALTH_W-1:0] sel_dmg, target, new_health;
    logic                apply;

    // Holds acks off through reset and the first cycle after release
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) run_q <= 1'b0;
        else          run_q <= 1'b1;
    end

    hit_arbiter u_arb (
        .clk     (vga_clk),
        .reset_n (reset_n),
        .enable  (run_q),
        .req_a   (ryu_hit_req),
        .dmg_a   (ryu_hit_dmg),
        .req_b   (akuma_hit_req),
        .dmg_b   (akuma_hit_dmg),
        .grant_a (ryu_hit_ack),
        .grant_b (akuma_hit_ack),
        .sel_dmg (sel_dmg)
    );

    // Damage only lands in FIGHT while nobody is already down; other grants are discarded
    assign apply      = (state == FIGHT) && (ryu_health != '0) && (akuma_health != '0);
    assign target     = ryu_hit_ack ? akuma_health : ryu_health;
    assign new_health = (target > sel_dmg) ? target - sel_dmg : '0;

    // Health and winner registers: reload on re-arm, saturating update on a served hit
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            ryu_health   <= MAX_HEALTH;
            akuma_health <= MAX_HEALTH;
            winner_q     <= WIN_NONE;
        end else if (state == RESULT && start) begin
            ryu_health   <= MAX_HEALTH;
            akuma_health <= MAX_HEALTH;
            winner_q     <= WIN_NONE;
        end else if (apply && ryu_hit_ack) begin
            akuma_health <= new_health;
            if (new_health == '0) winner_q <= WIN_RYU;
        end else if (apply && akuma_hit_ack) begin
            ryu_health <= new_health;
            if (new_health == '0) winner_q <= WIN_AKUMA;
        end
    end

    // Round state register
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) state <= INTRO;
        else          state <= next_state;
    end

    // Next-state decode
    always_comb begin
        next_state = state;
        case (state)
            INTRO:  if (frame_tick && frame_cnt == CNT_W'(INTRO_FRAMES - 1)) next_state = FIGHT;
            FIGHT:  if (ryu_health == '0 || akuma_health == '0) next_state = KO;
            KO:     if (frame_tick && frame_cnt == CNT_W'(KO_FRAMES - 1)) next_state = RESULT;
            RESULT: if (start) next_state = INTRO;
        endcase
    end

    // Frame counter restarts on every state change and counts ticks in the timed states
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt <= '0;
        end else if (next_state != state) begin
            frame_cnt <= '0;
        end else if (frame_tick && (state == INTRO || state == KO)) begin
            frame_cnt <= frame_cnt + 1'b1;
        end
    end

    // KO banner blink: on at KO entry, toggles every BLINK_FRAMES ticks, solid in RESULT
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            ko_blink  <= 1'b0;
            blink_cnt <= '0;
        end else if (next_state == KO && state != KO) begin
            ko_blink  <= 1'b1;
            blink_cnt <= '0;
        end else if (state == KO && next_state == KO) begin
            if (frame_tick) begin
                if (blink_cnt == 4'(BLINK_FRAMES - 1)) begin
                    ko_blink  <= ~ko_blink;
                    blink_cnt <= '0;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end
        end else begin
            ko_blink <= (next_state == RESULT);
        end
    end

    assign RyuHealth   = ryu_health;
    assign AkumaHealth = akuma_health;
    assign winner      = winner_q;
    assign state_o     = state;
    assign death       = (state == KO) || (state == RESULT);
    assign freeze      = (state != FIGHT);

endmodule

// File: tb/tb_fight_round_ctrl.sv
// tb/tb_fight_round_ctrl.sv - directed self-checking bench for fight_round_ctrl
module tb_fight_round_ctrl;

    logic       vga_clk = 1'b0;
    logic       reset_n;
    logic       frame_tick;
    logic       start;
    logic       ryu_hit_req;
    logic [7:0] ryu_hit_dmg;
    logic       ryu_hit_ack;
    logic       akuma_hit_req;
    logic [7:0] akuma_hit_dmg;
    logic       akuma_hit_ack;
    logic [7:0] RyuHealth;
    logic [7:0] AkumaHealth;
    logic       death;
    logic       ko_blink;
    logic       freeze;
    logic [1:0] winner;
    logic [1:0] state_o;

    int passed = 0;
    int total  = 0;

    fight_round_ctrl dut (
        .vga_clk       (vga_clk),
        .reset_n       (reset_n),
        .frame_tick    (frame_tick),
        .start         (start),
        .ryu_hit_req   (ryu_hit_req),
        .ryu_hit_dmg   (ryu_hit_dmg),
        .ryu_hit_ack   (ryu_hit_ack),
        .akuma_hit_req (akuma_hit_req),
        .akuma_hit_dmg (akuma_hit_dmg),
        .akuma_hit_ack (akuma_hit_ack),
        .RyuHealth     (RyuHealth),
        .AkumaHealth   (AkumaHealth),
        .death         (death),
        .ko_blink      (ko_blink),
        .freeze        (freeze),
        .winner        (winner),
        .state_o       (state_o)
    );

    always #5 vga_clk = ~vga_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            cyc();
        end
        frame_tick = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; frame_tick = 1'b0; start = 1'b0;
        ryu_hit_req = 1'b0; ryu_hit_dmg = 8'd0;
        akuma_hit_req = 1'b1; akuma_hit_dmg = 8'd5;
        cyc(); cyc();
        chk("rst_state", state_o, 0);
        chk("rst_ryu_hp", RyuHealth, 200);
        chk("rst_akuma_hp", AkumaHealth, 200);
        chk("rst_freeze", freeze, 1);
        chk("rst_death", death, 0);
        chk("rst_blink", ko_blink, 0);
        chk("rst_winner", winner, 0);
        chk("rst_no_ack", akuma_hit_ack, 0);
        akuma_hit_req = 1'b0;
        reset_n = 1'b1;
        cyc();

        // intro: 119 ticks still INTRO, the 120th enters FIGHT
        ticks(119);
        chk("intro_119_state", state_o, 0);
        chk("intro_119_freeze", freeze, 1);
        ticks(1);
        chk("intro_120_state", state_o, 1);
        chk("intro_120_freeze", freeze, 0);
        chk("fight_ryu_hp", RyuHealth, 200);
        chk("fight_akuma_hp", AkumaHealth, 200);

        // single Ryu hit of 30
        ryu_hit_req = 1'b1; ryu_hit_dmg = 8'd30; #1;
        chk("hit30_ack", ryu_hit_ack, 1);
        chk("hit30_other_ack", akuma_hit_ack, 0);
        cyc(); ryu_hit_req = 1'b0; #1;
        chk("hit30_akuma_hp", AkumaHealth, 170);
        chk("hit30_ryu_hp", RyuHealth, 200);
        chk("hit30_ack_drop", ryu_hit_ack, 0);

        // contention, rr_ptr=0: Ryu first, Akuma next
        ryu_hit_req = 1'b1; ryu_hit_dmg = 8'd10;
        akuma_hit_req = 1'b1; akuma_hit_dmg = 8'd10; #1;
        chk("rr0_ryu_ack", ryu_hit_ack, 1);
        chk("rr0_akuma_wait", akuma_hit_ack, 0);
        cyc(); ryu_hit_req = 1'b0; #1;
        chk("rr0_akuma_ack", akuma_hit_ack, 1);
        chk("rr0_akuma_hp", AkumaHealth, 160);
        cyc(); akuma_hit_req = 1'b0; #1;
        chk("rr0_ryu_hp", RyuHealth, 190);

        // contention again: pointer flipped, Akuma first
        ryu_hit_req = 1'b1; akuma_hit_req = 1'b1; #1;
        chk("rr1_akuma_ack", akuma_hit_ack, 1);
        chk("rr1_ryu_wait", ryu_hit_ack, 0);
        cyc(); akuma_hit_req = 1'b0; #1;
        chk("rr1_ryu_ack", ryu_hit_ack, 1);
        chk("rr1_ryu_hp", RyuHealth, 180);
        cyc(); ryu_hit_req = 1'b0; #1;
        chk("rr1_akuma_hp", AkumaHealth, 150);

        // zero damage
        ryu_hit_req = 1'b1; ryu_hit_dmg = 8'd0; #1;
        chk("dmg0_ack", ryu_hit_ack, 1);
        cyc(); ryu_hit_req = 1'b0; #1;
        chk("dmg0_akuma_hp", AkumaHealth, 150);

        // bring Akuma to 20, then saturate with 50
        ryu_hit_req = 1'b1; ryu_hit_dmg = 8'd130;
        cyc(); ryu_hit_req = 1'b0; #1;
        chk("to20_akuma_hp", AkumaHealth, 20);
        ryu_hit_req = 1'b1; ryu_hit_dmg = 8'd50; #1;
        chk("ko_hit_ack", ryu_hit_ack, 1);
        cyc(); ryu_hit_req = 1'b0; #1;
        chk("ko_akuma_hp", AkumaHealth, 0);
        chk("ko_winner", winner, 1);
        chk("ko_still_fight", state_o, 1);
        // request in the cycle health reads 0: acked, not applied
        akuma_hit_req = 1'b1; akuma_hit_dmg = 8'd40; #1;
        chk("late_ack", akuma_hit_ack, 1);
        cyc(); akuma_hit_req = 1'b0; #1;
        chk("ko_state", state_o, 2);
        chk("ko_death", death, 1);
        chk("ko_freeze", freeze, 1);
        chk("ko_blink_entry", ko_blink, 1);
        chk("late_ryu_hp", RyuHealth, 180);

        // blink cadence and KO duration
        ticks(14);
        chk("blink_14", ko_blink, 1);
        ticks(1);
        chk("blink_15", ko_blink, 0);
        ticks(15);
        chk("blink_30", ko_blink, 1);
        ticks(149);
        chk("ko_179_state", state_o, 2);
        ticks(1);
        chk("result_state", state_o, 3);
        chk("result_blink", ko_blink, 1);
        chk("result_death", death, 1);

        // request in RESULT
        akuma_hit_req = 1'b1; akuma_hit_dmg = 8'd25; #1;
        chk("result_req_ack", akuma_hit_ack, 1);
        cyc(); akuma_hit_req = 1'b0; #1;
        chk("result_ryu_hp", RyuHealth, 180);

        // re-arm
        start = 1'b1;
        cyc(); start = 1'b0; #1;
        chk("rearm_state", state_o, 0);
        chk("rearm_ryu_hp", RyuHealth, 200);
        chk("rearm_akuma_hp", AkumaHealth, 200);
        chk("rearm_winner", winner, 0);
        chk("rearm_blink", ko_blink, 0);
        chk("rearm_death", death, 0);

        // request in INTRO, start ignored outside RESULT
        akuma_hit_req = 1'b1; akuma_hit_dmg = 8'd25; start = 1'b1; #1;
        chk("intro_req_ack", akuma_hit_ack, 1);
        cyc(); akuma_hit_req = 1'b0; start = 1'b0; #1;
        chk("intro_ryu_hp", RyuHealth, 200);
        chk("intro_start_ign", state_o, 0);

        // second round: Akuma wins, then reset mid-KO with a pending request
        ticks(120);
        chk("r2_fight", state_o, 1);
        akuma_hit_req = 1'b1; akuma_hit_dmg = 8'd255;
        cyc(); akuma_hit_req = 1'b0; #1;
        chk("r2_ryu_hp", RyuHealth, 0);
        chk("r2_winner", winner, 2);
        cyc();
        chk("r2_ko", state_o, 2);
        ticks(40);
        akuma_hit_req = 1'b1; reset_n = 1'b0; #1;
        chk("rst_ko_no_ack", akuma_hit_ack, 0);
        chk("rst_ko_state", state_o, 0);
        chk("rst_ko_ryu_hp", RyuHealth, 200);
        chk("rst_ko_winner", winner, 0);
        chk("rst_ko_blink", ko_blink, 0);
        cyc(); cyc();
        chk("rst_hold_no_ack", akuma_hit_ack, 0);
        chk("rst_hold_death", death, 0);
        akuma_hit_req = 1'b0; reset_n = 1'b1;
        cyc();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
